// File: rtl/nread_burst_engine.sv
// nread_burst_engine: splits a DMA read into SRIO NREAD requests and writes the HELLO responses to AXI.
// Latency: first request the cycle after start; response data flows to W combinationally after one AW cycle.
// Backpressure: requests stall at OUTSTANDING in flight; iresp tready follows wready during data beats.
// Optional response watchdog: define NREAD_TIMEOUT_EN.
module nread_burst_engine #(
    parameter int         MAX_BURST_DW = 32,
    parameter int         OUTSTANDING  = 4,
    parameter logic [1:0] PRIO         = 2'b01
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        nread_start,
    input  logic [31:0] srcAddr,
    input  logic [31:0] dstAddr,
    input  logic [15:0] size_dw,
    output logic        nread_irq,
    output logic        nread_finish,
    output logic        nread_err,
    output logic        m_axis_ireq_tvalid,
    input  logic        m_axis_ireq_tready,
    output logic [63:0] m_axis_ireq_tdata,
    output logic        m_axis_ireq_tlast,
    input  logic        s_axis_iresp_tvalid,
    output logic        s_axis_iresp_tready,
    input  logic [63:0] s_axis_iresp_tdata,
    input  logic [7:0]  s_axis_iresp_tkeep,
    input  logic        s_axis_iresp_tlast,
    output logic [31:0] m_axi_awaddr,
    output logic [7:0]  m_axi_awlen,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [63:0] m_axi_wdata,
    output logic        m_axi_wlast,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready
);
    localparam int SW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW = $clog2(OUTSTANDING + 1);

    typedef enum logic [1:0] {T_IDLE, T_ISSUE, T_DRAIN} top_state_t;
    typedef enum logic [1:0] {R_HDR, R_AW, R_DATA, R_DROP} rsp_state_t;

    top_state_t r_top, w_top_nxt;
    rsp_state_t r_rsp, w_rsp_nxt;

    logic [31:0]            r_src, r_dst;
    logic [15:0]            r_rem;
    logic [SW-1:0]          r_tid;
    logic [CW-1:0]          r_outst;
    logic [OUTSTANDING-1:0] r_slot_vld;
    logic [31:0]            r_slot_dst [OUTSTANDING];
    logic [7:0]             r_slot_len [OUTSTANDING];
    logic [SW-1:0]          r_cur_idx;
    logic [31:0]            r_cur_dst;
    logic [7:0]             r_cur_len, r_beat;
    logic                   r_live, r_irq, r_finish, r_err;

    logic [15:0]   w_page_dw, w_lim, w_b;
    logic [7:0]    w_size;
    logic          w_issue_vld, w_issue, w_accept, w_done;
    logic [7:0]    w_hdr_tid;
    logic [SW-1:0] w_hdr_idx, w_free_idx;
    logic          w_hdr_hit, w_hdr_ok, w_load, w_free, w_free_vld, w_rsp_err;
    logic          w_unused_tkeep;

    assign w_unused_tkeep = ^s_axis_iresp_tkeep;

    // Burst sizing: clip to remaining, max burst and the 4 KB page, then round to 1/2/4/4n.
    always_comb begin
        w_page_dw = {3'b000, 13'h1000 - {1'b0, r_dst[11:0]}} >> 3;
        w_lim = r_rem;
        if (w_lim > 16'(MAX_BURST_DW)) w_lim = 16'(MAX_BURST_DW);
        if (w_lim > w_page_dw)         w_lim = w_page_dw;
        if (w_lim >= 16'd4)            w_b = w_lim & 16'hFFFC;
        else if (w_lim == 16'd3)       w_b = 16'd2;
        else                           w_b = w_lim;
    end

    // A slot still held by an out-of-order response blocks reuse of that tid.
    assign w_issue_vld = (r_top == T_ISSUE) && (r_rem != '0) &&
                         (r_outst < CW'(OUTSTANDING)) && !r_slot_vld[r_tid];
    assign w_issue     = w_issue_vld && m_axis_ireq_tready;
    assign w_size      = 8'((w_b << 3) - 16'd1);

    assign m_axis_ireq_tvalid = w_issue_vld;
    assign m_axis_ireq_tlast  = w_issue_vld;
    assign m_axis_ireq_tdata  = {8'(r_tid), 4'h2, 4'h4, 1'b0, PRIO, 1'b0, w_size, 2'b00, 2'b00, r_src};

    assign w_hdr_tid = s_axis_iresp_tdata[63:56];
    assign w_hdr_idx = s_axis_iresp_tdata[56 +: SW];
    assign w_hdr_hit = (w_hdr_tid < 8'(OUTSTANDING)) && r_slot_vld[w_hdr_idx];
    assign w_hdr_ok  = w_hdr_hit && (s_axis_iresp_tdata[55:52] == 4'hD) &&
                       (s_axis_iresp_tdata[51:48] == 4'h8);
    assign w_free_vld = w_free && r_slot_vld[w_free_idx];

    assign m_axi_awaddr = r_cur_dst;
    assign m_axi_awlen  = r_cur_len;
    assign m_axi_wdata  = s_axis_iresp_tdata;
    assign nread_irq    = r_irq;
    assign nread_err    = r_err;
    assign nread_finish = r_finish;

    // Top FSM state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_top <= T_IDLE;
        else          r_top <= w_top_nxt;
    end

    // Top FSM next state: accept start, finish once everything issued has returned.
    always_comb begin
        w_top_nxt = r_top;
        w_accept  = 1'b0;
        w_done    = 1'b0;
        case (r_top)
            T_IDLE: if (nread_start) begin
                w_accept = 1'b1;
                if (size_dw == 16'd0) w_done = 1'b1;
                else                  w_top_nxt = T_ISSUE;
            end
            T_ISSUE: if (r_rem == '0) begin
                if (r_outst == '0) begin w_done = 1'b1; w_top_nxt = T_IDLE; end
                else               w_top_nxt = T_DRAIN;
            end
            T_DRAIN: if (r_outst == '0) begin w_done = 1'b1; w_top_nxt = T_IDLE; end
            default: w_top_nxt = T_IDLE;
        endcase
    end

    // Response FSM: header decode, AW issue, data pass-through, error drop.
    always_comb begin
        w_rsp_nxt           = r_rsp;
        s_axis_iresp_tready = 1'b0;
        m_axi_awvalid       = 1'b0;
        m_axi_wvalid        = 1'b0;
        m_axi_wlast         = 1'b0;
        w_free              = 1'b0;
        w_free_idx          = r_cur_idx;
        w_rsp_err           = 1'b0;
        w_load              = 1'b0;
        case (r_rsp)
            R_HDR: begin
                s_axis_iresp_tready = r_live;
                if (s_axis_iresp_tvalid && r_live) begin
                    if (w_hdr_ok && !s_axis_iresp_tlast) begin
                        w_load    = 1'b1;
                        w_rsp_nxt = R_AW;
                    end else begin
                        w_rsp_err  = 1'b1;
                        w_free     = w_hdr_hit;
                        w_free_idx = w_hdr_idx;
                        if (!s_axis_iresp_tlast) w_rsp_nxt = R_DROP;
                    end
                end
            end
            R_AW: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) w_rsp_nxt = R_DATA;
            end
            R_DATA: begin
                s_axis_iresp_tready = m_axi_wready;
                m_axi_wvalid        = s_axis_iresp_tvalid;
                m_axi_wlast         = (r_beat == r_cur_len);
                if (s_axis_iresp_tvalid && m_axi_wready) begin
                    if (r_beat == r_cur_len) begin
                        w_free = 1'b1;
                        if (!s_axis_iresp_tlast) begin w_rsp_err = 1'b1; w_rsp_nxt = R_DROP; end
                        else                     w_rsp_nxt = R_HDR;
                    end else if (s_axis_iresp_tlast) begin
                        w_rsp_err = 1'b1;
                        w_free    = 1'b1;
                        w_rsp_nxt = R_HDR;
                    end
                end
            end
            R_DROP: begin
                s_axis_iresp_tready = 1'b1;
                if (s_axis_iresp_tvalid && s_axis_iresp_tlast) w_rsp_nxt = R_HDR;
            end
            default: w_rsp_nxt = R_HDR;
        endcase
    end

    // Response FSM state plus the context of the burst being written.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rsp     <= R_HDR;
            r_live    <= 1'b0;
            r_cur_idx <= '0;
            r_cur_dst <= '0;
            r_cur_len <= '0;
            r_beat    <= '0;
        end else begin
            r_rsp  <= w_rsp_nxt;
            r_live <= 1'b1;
            if (w_load) begin
                r_cur_idx <= w_hdr_idx;
                r_cur_dst <= r_slot_dst[w_hdr_idx];
                r_cur_len <= r_slot_len[w_hdr_idx];
                r_beat    <= '0;
            end else if (r_rsp == R_DATA && s_axis_iresp_tvalid && m_axi_wready) begin
                r_beat <= r_beat + 8'd1;
            end
        end
    end

`ifdef NREAD_TIMEOUT_EN
    logic [23:0] r_wd;
    logic        w_iresp_hs;
    assign w_iresp_hs = s_axis_iresp_tvalid && s_axis_iresp_tready;
`endif

    // Request datapath, slot table, outstanding count and status flags.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_src      <= '0;
            r_dst      <= '0;
            r_rem      <= '0;
            r_tid      <= '0;
            r_outst    <= '0;
            r_slot_vld <= '0;
            for (int i = 0; i < OUTSTANDING; i++) begin
                r_slot_dst[i] <= '0;
                r_slot_len[i] <= '0;
            end
            r_irq    <= 1'b0;
            r_err    <= 1'b0;
            r_finish <= 1'b0;
`ifdef NREAD_TIMEOUT_EN
            r_wd     <= '0;
`endif
        end else begin
            r_finish <= w_done;
            if (w_accept) begin
                r_src <= srcAddr & ~32'h7;
                r_dst <= dstAddr & ~32'h7;
                r_rem <= size_dw;
                r_irq <= 1'b0;
                r_err <= 1'b0;
            end
            if (w_free_vld) r_slot_vld[w_free_idx] <= 1'b0;
            if (w_issue) begin
                r_slot_vld[r_tid] <= 1'b1;
                r_slot_dst[r_tid] <= r_dst;
                r_slot_len[r_tid] <= 8'(w_b - 16'd1);
                r_src <= r_src + 32'({w_b, 3'b000});
                r_dst <= r_dst + 32'({w_b, 3'b000});
                r_rem <= r_rem - w_b;
                r_tid <= (r_tid == SW'(OUTSTANDING - 1)) ? '0 : r_tid + 1'b1;
            end
            r_outst <= r_outst + CW'(w_issue) - CW'(w_free_vld);
            if (w_rsp_err) r_err <= 1'b1;
            if (w_done)    r_irq <= 1'b1;
`ifdef NREAD_TIMEOUT_EN
            if (r_outst == '0 || w_iresp_hs) r_wd <= '0;
            else                             r_wd <= r_wd + 24'd1;
            if (r_wd == 24'hFF_FFFF) begin
                r_err      <= 1'b1;
                r_slot_vld <= '0;
                r_outst    <= '0;
                r_rem      <= '0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_nread_burst_engine.sv
module tb_nread_burst_engine;
    logic        aclk = 1'b0;
    logic        aresetn;
    logic        nread_start;
    logic [31:0] srcAddr, dstAddr;
    logic [15:0] size_dw;
    logic        nread_irq, nread_finish, nread_err;
    logic        m_axis_ireq_tvalid, m_axis_ireq_tready, m_axis_ireq_tlast;
    logic [63:0] m_axis_ireq_tdata;
    logic        s_axis_iresp_tvalid, s_axis_iresp_tready, s_axis_iresp_tlast;
    logic [63:0] s_axis_iresp_tdata;
    logic [7:0]  s_axis_iresp_tkeep;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic        m_axi_awvalid, m_axi_awready;
    logic [63:0] m_axi_wdata;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;

    int errors = 0;
    int checks = 0;
    int fin_cnt = 0;
    logic [63:0] req_q[$];
    logic [39:0] aw_q[$];
    logic [64:0] w_q[$];

    always #5 aclk = ~aclk;

    nread_burst_engine #(.MAX_BURST_DW(32), .OUTSTANDING(2), .PRIO(2'b01)) dut (
        .aclk(aclk), .aresetn(aresetn), .nread_start(nread_start),
        .srcAddr(srcAddr), .dstAddr(dstAddr), .size_dw(size_dw),
        .nread_irq(nread_irq), .nread_finish(nread_finish), .nread_err(nread_err),
        .m_axis_ireq_tvalid(m_axis_ireq_tvalid), .m_axis_ireq_tready(m_axis_ireq_tready),
        .m_axis_ireq_tdata(m_axis_ireq_tdata), .m_axis_ireq_tlast(m_axis_ireq_tlast),
        .s_axis_iresp_tvalid(s_axis_iresp_tvalid), .s_axis_iresp_tready(s_axis_iresp_tready),
        .s_axis_iresp_tdata(s_axis_iresp_tdata), .s_axis_iresp_tkeep(s_axis_iresp_tkeep),
        .s_axis_iresp_tlast(s_axis_iresp_tlast),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready)
    );

    // Handshake monitors sample mid-cycle, when the next rising edge's inputs are settled.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (m_axis_ireq_tvalid && m_axis_ireq_tready) req_q.push_back(m_axis_ireq_tdata);
            if (m_axi_awvalid && m_axi_awready) aw_q.push_back({m_axi_awaddr, m_axi_awlen});
            if (m_axi_wvalid && m_axi_wready) w_q.push_back({m_axi_wlast, m_axi_wdata});
            if (nread_finish) fin_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1);
    end

    function automatic int wlast_cnt();
        int c;
        c = 0;
        foreach (w_q[k]) c += int'(w_q[k][64]);
        return c;
    endfunction

    task automatic do_reset();
        aresetn = 1'b0;
        nread_start = 1'b0;
        s_axis_iresp_tvalid = 1'b0;
        s_axis_iresp_tlast = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        req_q.delete(); aw_q.delete(); w_q.delete(); fin_cnt = 0;
        aresetn = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        srcAddr = s; dstAddr = d; size_dw = n; nread_start = 1'b1;
        @(posedge aclk); #1;
        nread_start = 1'b0;
    endtask

    task automatic wait_req(input int n);
        int t;
        t = 0;
        while (req_q.size() < n && t < 300) begin @(posedge aclk); #1; t++; end
    endtask

    task automatic wait_finish(input int n);
        int t;
        t = 0;
        while (fin_cnt < n && t < 1000) begin @(posedge aclk); #1; t++; end
        repeat (3) @(posedge aclk);
        #1;
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic l);
        int t;
        logic hs;
        s_axis_iresp_tvalid = 1'b1; s_axis_iresp_tdata = d; s_axis_iresp_tlast = l;
        t = 0; hs = 1'b0;
        while (!hs && t < 200) begin
            @(negedge aclk); hs = s_axis_iresp_tready;
            @(posedge aclk); #1; t++;
        end
        if (!hs) begin
            checks++; errors++;
            $display("FAIL iresp_beat_timeout: tready=%b, required 1", hs);
        end
    endtask

    task automatic send_resp(input logic [7:0] tid, input logic [3:0] ft, input int nb);
        drive_beat({tid, ft, 4'h8, 48'h0}, nb == 0);
        for (int j = 0; j < nb; j++) drive_beat({16'hA5A5, 32'h0, tid, 8'(j)}, j == nb - 1);
        s_axis_iresp_tvalid = 1'b0; s_axis_iresp_tlast = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        nread_start = 1'b0; srcAddr = '0; dstAddr = '0; size_dw = '0;
        s_axis_iresp_tvalid = 1'b0; s_axis_iresp_tdata = '0; s_axis_iresp_tkeep = 8'hFF;
        s_axis_iresp_tlast = 1'b0;
        m_axis_ireq_tready = 1'b1; m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        checks++; if ({m_axis_ireq_tvalid, m_axis_ireq_tlast} !== 2'b00) begin errors++;
            $display("FAIL reset_ireq: got %b, required 00", {m_axis_ireq_tvalid, m_axis_ireq_tlast}); end
        checks++; if (s_axis_iresp_tready !== 1'b0) begin errors++;
            $display("FAIL reset_iresp_tready: got %b, required 0", s_axis_iresp_tready); end
        checks++; if ({nread_irq, nread_finish, nread_err} !== 3'b000) begin errors++;
            $display("FAIL reset_status: got %b, required 000", {nread_irq, nread_finish, nread_err}); end
        checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_wlast} !== 3'b000) begin errors++;
            $display("FAIL reset_axi: got %b, required 000", {m_axi_awvalid, m_axi_wvalid, m_axi_wlast}); end
        do_reset();
        checks++; if (s_axis_iresp_tready !== 1'b1) begin errors++;
            $display("FAIL idle_iresp_tready: got %b, required 1", s_axis_iresp_tready); end
    endtask

    task automatic test_simple();
        do_reset();
        do_start(32'h1000, 32'h8000, 16'd32);
        wait_req(1);
        checks++; if (req_q.size() != 1 || req_q[0] !== 64'h0024_2FF0_0000_1000) begin errors++;
            $display("FAIL simple_req: got n=%0d %h, required n=1 0024_2ff0_0000_1000", req_q.size(), m_axis_ireq_tdata); end
        send_resp(8'd0, 4'hD, 32);
        wait_finish(1);
        checks++; if (aw_q.size() != 1 || aw_q[0] !== {32'h8000, 8'd31}) begin errors++;
            $display("FAIL simple_aw: got n=%0d, required 1 entry 8000/31", aw_q.size()); end
        checks++; if (w_q.size() != 32 || wlast_cnt() != 1 || w_q[31] !== {1'b1, 64'hA5A5_0000_0000_001F}) begin errors++;
            $display("FAIL simple_w: got beats=%0d wlast=%0d, required 32 and 1 on beat 31", w_q.size(), wlast_cnt()); end
        checks++; if (w_q[0] !== {1'b0, 64'hA5A5_0000_0000_0000}) begin errors++;
            $display("FAIL simple_w0: got %h, required 0a5a5000000000000", w_q[0]); end
        checks++; if (fin_cnt != 1 || nread_irq !== 1'b1 || nread_err !== 1'b0) begin errors++;
            $display("FAIL simple_done: got fin=%0d irq=%b err=%b, required 1 1 0", fin_cnt, nread_irq, nread_err); end
    endtask

    task automatic test_split();
        logic [63:0] exp_req [4] = '{64'h0024_2FF0_0000_2000, 64'h0124_2FF0_0000_2100,
                                     64'h0024_21F0_0000_2200, 64'h0124_20F0_0000_2220};
        logic [39:0] exp_aw [4] = '{{32'h10000, 8'd31}, {32'h10100, 8'd31},
                                    {32'h10200, 8'd3}, {32'h10220, 8'd1}};
        int b [4] = '{32, 32, 4, 2};
        do_reset();
        do_start(32'h2000, 32'h10000, 16'd70);
        for (int i = 0; i < 4; i++) begin
            wait_req(i + 1);
            checks++; if (req_q.size() <= i || req_q[i] !== exp_req[i]) begin errors++;
                $display("FAIL split_req%0d: got n=%0d, required %h", i, req_q.size(), exp_req[i]); end
            if (i >= 1) send_resp(8'((i - 1) % 2), 4'hD, b[i - 1]);
        end
        send_resp(8'd1, 4'hD, 2);
        wait_finish(1);
        for (int i = 0; i < 4; i++) begin
            checks++; if (aw_q.size() <= i || aw_q[i] !== exp_aw[i]) begin errors++;
                $display("FAIL split_aw%0d: got n=%0d, required %h", i, aw_q.size(), exp_aw[i]); end
        end
        checks++; if (w_q.size() != 70 || wlast_cnt() != 4 || fin_cnt != 1) begin errors++;
            $display("FAIL split_w: got beats=%0d wlast=%0d fin=%0d, required 70 4 1", w_q.size(), wlast_cnt(), fin_cnt); end
    endtask

    task automatic test_clip();
        do_reset();
        do_start(32'h3000, 32'h8FC0, 16'd32);
        wait_req(2);
        checks++; if (req_q.size() != 2 || req_q[0] !== 64'h0024_23F0_0000_3000 || req_q[1] !== 64'h0124_2BF0_0000_3040) begin errors++;
            $display("FAIL clip_req: got n=%0d, required B=8 then B=24", req_q.size()); end
        send_resp(8'd0, 4'hD, 8);
        send_resp(8'd1, 4'hD, 24);
        wait_finish(1);
        checks++; if (aw_q.size() != 2 || aw_q[0] !== {32'h8FC0, 8'd7} || aw_q[1] !== {32'h9000, 8'd23}) begin errors++;
            $display("FAIL clip_aw: got n=%0d, required 8fc0/7 then 9000/23", aw_q.size()); end
        checks++; if (w_q.size() != 32 || fin_cnt != 1) begin errors++;
            $display("FAIL clip_w: got beats=%0d fin=%0d, required 32 1", w_q.size(), fin_cnt); end
    endtask

    task automatic test_backpressure();
        do_reset();
        do_start(32'h6000, 32'h20000, 16'd128);
        repeat (30) @(posedge aclk);
        #1;
        checks++; if (req_q.size() != 2) begin errors++;
            $display("FAIL bp_withheld: got %0d requests, required 2", req_q.size()); end
        send_resp(8'd0, 4'hD, 32);
        repeat (30) @(posedge aclk);
        #1;
        checks++; if (req_q.size() != 3) begin errors++;
            $display("FAIL bp_one_more: got %0d requests, required 3", req_q.size()); end
        send_resp(8'd1, 4'hD, 32);
        wait_req(4);
        send_resp(8'd0, 4'hD, 32);
        send_resp(8'd1, 4'hD, 32);
        wait_finish(1);
        checks++; if (req_q.size() != 4 || w_q.size() != 128 || fin_cnt != 1) begin errors++;
            $display("FAIL bp_done: got req=%0d beats=%0d fin=%0d, required 4 128 1", req_q.size(), w_q.size(), fin_cnt); end
    endtask

    task automatic test_bad_resp();
        do_reset();
        do_start(32'h1000, 32'h8000, 16'd32);
        wait_req(1);
        send_resp(8'd0, 4'hA, 32);
        wait_finish(1);
        checks++; if (aw_q.size() != 0 || w_q.size() != 0) begin errors++;
            $display("FAIL bad_axi: got aw=%0d w=%0d, required 0 0", aw_q.size(), w_q.size()); end
        checks++; if (nread_err !== 1'b1 || fin_cnt != 1 || nread_irq !== 1'b1) begin errors++;
            $display("FAIL bad_status: got err=%b fin=%0d irq=%b, required 1 1 1", nread_err, fin_cnt, nread_irq); end
        do_start(32'h0, 32'h0, 16'd0);
        checks++; if (nread_err !== 1'b0) begin errors++;
            $display("FAIL err_clear_on_start: got %b, required 0", nread_err); end
    endtask

    task automatic test_corner();
        do_reset();
        do_start(32'h7000, 32'hC000, 16'd0);
        checks++; if ({nread_finish, nread_irq} !== 2'b11) begin errors++;
            $display("FAIL zero_finish: got fin,irq=%b, required 11", {nread_finish, nread_irq}); end
        @(posedge aclk); #1;
        checks++; if (nread_finish !== 1'b0 || req_q.size() != 0 || nread_irq !== 1'b1) begin errors++;
            $display("FAIL zero_after: got fin=%b req=%0d irq=%b, required 0 0 1", nread_finish, req_q.size(), nread_irq); end
        do_start(32'h4007, 32'hA003, 16'd64);
        do_start(32'h5000, 32'hB000, 16'd8);
        wait_req(2);
        checks++; if (req_q.size() != 2 || req_q[0] !== 64'h0024_2FF0_0000_4000 || req_q[1] !== 64'h0124_2FF0_0000_4100) begin errors++;
            $display("FAIL busy_start_req: got n=%0d, required 4000 then 4100", req_q.size()); end
        send_resp(8'd0, 4'hD, 32);
        send_resp(8'd1, 4'hD, 32);
        wait_finish(2);
        checks++; if (aw_q.size() != 2 || aw_q[0] !== {32'hA000, 8'd31} || aw_q[1] !== {32'hA100, 8'd31}) begin errors++;
            $display("FAIL busy_start_aw: got n=%0d, required a000/31 then a100/31", aw_q.size()); end
        checks++; if (w_q.size() != 64 || fin_cnt != 2) begin errors++;
            $display("FAIL busy_start_done: got beats=%0d fin=%0d, required 64 2", w_q.size(), fin_cnt); end
    endtask

    initial begin
        test_reset();
        test_simple();
        test_split();
        test_clip();
        test_backpressure();
        test_bad_resp();
        test_corner();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
